// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a len-word burst from the FIFO read port onto a valid/ready stream
module fifo_stream_reader #(
    parameter int DATA_BUS_SIZE = 32,
    parameter int Data_Width    = DATA_BUS_SIZE,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_left,
    input  logic                  fifo_empt,
    output logic                  fifo_rd,
    input  logic [Data_Width-1:0] fifo_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Data_Width-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [Data_Width-1:0] buf0;
    logic [Data_Width-1:0] buf1;
    logic                  pop;

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf0;
    assign out_last  = out_valid && (words_left == LEN_WIDTH'(1));
    assign pop       = out_valid && out_ready;

    // Reads already in flight count as buffer space taken, so the 2-entry buffer never overflows.
    assign fifo_rd = (state == S_READ) && (issue_left != '0) && !fifo_empt &&
                     (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            issue_left <= '0;
            words_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            inflight <= fifo_rd;
            if (fifo_rd)
                issue_left <= issue_left - LEN_WIDTH'(1);
            if (pop)
                words_left <= words_left - LEN_WIDTH'(1);

            // buf0 is the head; a capture lands behind whatever survives this cycle's pop.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        buf0 <= fifo_data;
                    else
                        buf1 <= fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_data;
                    end
                end
                default: ;
            endcase

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy       <= 1'b1;
                        words_left <= len;
                        issue_left <= len;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (pop && (words_left == LEN_WIDTH'(1))) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_left;
    logic          fifo_empt;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    fifo_stream_reader #(.DATA_BUS_SIZE(DW), .Data_Width(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .words_left(words_left), .fifo_empt(fifo_empt), .fifo_rd(fifo_rd),
        .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // FIFO model: unbounded in-order store, registered read data.
    logic [DW-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    assign fifo_empt = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd && !fifo_empt) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    logic [DW:0] got_q[$];
    logic prev_ok = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (rst) begin
            if (fifo_rd) rd_cnt++;
            if (fifo_empt) chk("rd_while_empty", fifo_rd, 0);
            if (prev_ok && prev_valid && !prev_ready) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_ok    = 1'b1;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_ok = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic start_burst(input int n);
        start = 1'b1;
        len   = LW'(n);
        tick();
        start_cyc = cyc;
        start = 1'b0;
        len   = LW'($urandom);
    endtask

    task automatic wait_done(input bit rnd);
        int snap;
        snap = done_cnt;
        for (int i = 0; i < 400 && done_cnt == snap; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("done_timeout", done_cnt != snap, 1);
        out_ready = 1'b1;
    endtask

    task automatic compare_burst(input string tag, input int gbase, input int mbase, input int n);
        chk({tag, "_count"}, got_q.size() - gbase, n);
        for (int i = 0; i < n && gbase + i < got_q.size(); i++) begin
            chk({tag, "_data"}, got_q[gbase+i][DW-1:0], mem[mbase+i]);
            chk({tag, "_last"}, got_q[gbase+i][DW], (i == n - 1));
        end
    endtask

    int gb, mb, rb, n;

    initial begin
        // Reset and idle: no reads even with data waiting.
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_words_left", words_left, 0);
        chk("rst_rd", fifo_rd, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(32'h11 + i));
        for (int i = 0; i < 5; i++) tick();
        chk("idle_rd_cnt", rd_cnt, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);

        // Streaming burst of 8 with downstream always ready.
        out_ready = 1'b1;
        gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
        start_burst(8);
        chk("stream_busy", busy, 1);
        chk("stream_words_left", words_left, 8);
        chk("stream_valid_n0", out_valid, 0);
        tick();
        chk("stream_valid_n1", out_valid, 0);
        tick();
        chk("stream_valid_n2", out_valid, 1);
        chk("stream_first", out_data, 32'h11);
        wait_done(1'b0);
        chk("stream_done_cycle", done_cyc - start_cyc, 10);
        chk("stream_rd_cnt", rd_cnt - rb, 8);
        compare_burst("stream", gb, mb, 8);
        chk("stream_idle_busy", busy, 0);
        chk("stream_idle_done", done, 0);

        // Backpressure: reads stop at two beyond accepted words.
        for (int i = 0; i < 4; i++) push_word(DW'($urandom));
        out_ready = 1'b0;
        gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
        start_burst(4);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_rd_cnt", rd_cnt - rb, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, mem[mb]);
        chk("bp_words_left", words_left, 4);
        out_ready = 1'b1;
        wait_done(1'b0);
        chk("bp_rd_total", rd_cnt - rb, 4);
        compare_burst("bp", gb, mb, 4);

        // Empty stall: two words available, three more arrive later.
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
        start_burst(5);
        for (int i = 0; i < 20; i++) tick();
        chk("stall_rd_cnt", rd_cnt - rb, 2);
        chk("stall_got", got_q.size() - gb, 2);
        chk("stall_words_left", words_left, 3);
        chk("stall_busy", busy, 1);
        for (int i = 0; i < 3; i++) push_word(DW'($urandom));
        wait_done(1'b0);
        chk("stall_rd_total", rd_cnt - rb, 5);
        compare_burst("stall", gb, mb, 5);

        // Zero-length burst: done on the next cycle, no reads.
        for (int i = 0; i < 5; i++) push_word(DW'($urandom));
        rb = rd_cnt;
        start_burst(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_done_cycle", done_cyc - start_cyc, 0);
        chk("zero_done_clear", done, 0);
        chk("zero_busy_clear", busy, 0);
        chk("zero_rd_cnt", rd_cnt - rb, 0);

        // Start pulsed mid-burst is ignored.
        gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
        start_burst(3);
        start = 1'b1;
        len   = LW'(6);
        tick();
        start = 1'b0;
        wait_done(1'b1);
        compare_burst("ign", gb, mb, 3);
        for (int i = 0; i < 5; i++) tick();
        chk("ign_rd_cnt", rd_cnt - rb, 3);
        chk("ign_busy", busy, 0);

        // Reset mid-burst after three words delivered.
        for (int i = 0; i < 8; i++) push_word(DW'($urandom));
        gb = got_q.size();
        start_burst(8);
        for (int i = 0; i < 50 && got_q.size() - gb < 3; i++) tick();
        chk("mrst_got", got_q.size() - gb, 3);
        rst = 1'b0;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_words_left", words_left, 0);
        chk("mrst_rd", fifo_rd, 0);
        rst = 1'b1;
        tick();
        gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
        start_burst(2);
        wait_done(1'b0);
        chk("mrst2_rd_cnt", rd_cnt - rb, 2);
        compare_burst("mrst2", gb, mb, 2);

        // Random bursts with random downstream readiness.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) push_word(DW'($urandom));
            gb = got_q.size(); mb = rd_ptr; rb = rd_cnt;
            out_ready = 1'($urandom_range(0, 1));
            start_burst(n);
            wait_done(1'b1);
            chk("rand_rd_cnt", rd_cnt - rb, n);
            compare_burst("rand", gb, mb, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
